// File: rtl/ins_fetch.sv
// Instruction fetch unit: drives the instruction ROM from a program counter, assembles
// one- or two-word instructions and hands them to the decoder over valid/ready.
module ins_fetch #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter logic [1:0]        TWO_WORD_SEL = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] ROM_addr,
  input  logic [DATA_W-1:0] ROM_InsSet,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_word,
  output logic [DATA_W-1:0] ins_imm,
  output logic              ins_two_word,
  output logic [ADDR_W-1:0] ins_pc
);

  typedef enum logic [2:0] {IDLE, F1, C1, F2, C2, OUT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, rom_addr_nxt, ins_pc_nxt;
  logic [DATA_W-1:0] word_nxt, imm_nxt;
  logic              two_nxt;
  logic              is_two;
  logic              accept;

  assign ins_valid = (state == OUT);
  assign accept    = ins_valid & ins_ready;
  assign is_two    = (ROM_InsSet[13:12] == TWO_WORD_SEL);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    rom_addr_nxt = ROM_addr;
    word_nxt     = ins_word;
    imm_nxt      = ins_imm;
    two_nxt      = ins_two_word;
    ins_pc_nxt   = ins_pc;
    case (state)
      IDLE: begin
        rom_addr_nxt = pc;
        if (fetch_en) state_nxt = F1;
      end
      F1: state_nxt = C1;
      C1: begin
        word_nxt   = ROM_InsSet;
        ins_pc_nxt = pc;
        imm_nxt    = '0;
        two_nxt    = 1'b0;
        if (is_two) begin
          rom_addr_nxt = pc + ADDR_W'(1);
          state_nxt    = F2;
        end else begin
          state_nxt = OUT;
        end
      end
      F2: state_nxt = C2;
      C2: begin
        imm_nxt   = ROM_InsSet;
        two_nxt   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (accept) begin
          pc_nxt       = pc + (ins_two_word ? ADDR_W'(2) : ADDR_W'(1));
          rom_addr_nxt = pc_nxt;
          state_nxt    = fetch_en ? F1 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A redirect overrides everything, including the pc advance of a coincident accept.
    if (branch_valid) begin
      pc_nxt       = branch_addr;
      rom_addr_nxt = branch_addr;
      state_nxt    = fetch_en ? F1 : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ROM_addr     <= RESET_PC;
      ins_pc       <= RESET_PC;
      ins_word     <= '0;
      ins_imm      <= '0;
      ins_two_word <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      ROM_addr     <= rom_addr_nxt;
      ins_pc       <= ins_pc_nxt;
      ins_word     <= word_nxt;
      ins_imm      <= imm_nxt;
      ins_two_word <= two_nxt;
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: registered-read ROM model, scoreboard of expected instructions
// checked at every decoder accept, table of single-instruction vectors plus corner sequences.
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, branch_valid, ins_ready;
  logic [15:0] branch_addr;
  logic [15:0] ROM_addr, ROM_InsSet;
  logic        ins_valid, ins_two_word;
  logic [15:0] ins_word, ins_imm, ins_pc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] imm;
    logic        two;
    logic [15:0] pc;
  } ins_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        two;
    logic [15:0] nxt;
  } vec_t;

  ins_t exp_q[$];
  bit [15:0] rom [0:65535];

  ins_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .branch_valid(branch_valid),
    .branch_addr(branch_addr), .ROM_addr(ROM_addr), .ROM_InsSet(ROM_InsSet),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
    .ins_imm(ins_imm), .ins_two_word(ins_two_word), .ins_pc(ins_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ROM_InsSet <= rom[ROM_addr];

  // Scoreboard: every accepted instruction must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && ins_valid && ins_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ins: got word %h imm %h two %0d pc %h, want none",
                 ins_word, ins_imm, ins_two_word, ins_pc);
      end else begin
        ins_t e;
        e = exp_q.pop_front();
        if (ins_word !== e.word || ins_imm !== e.imm || ins_two_word !== e.two || ins_pc !== e.pc) begin
          fails++;
          $display("FAIL ins_out: got word %h imm %h two %0d pc %h, want word %h imm %h two %0d pc %h",
                   ins_word, ins_imm, ins_two_word, ins_pc, e.word, e.imm, e.two, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] imm, input logic two,
                      input logic [15:0] pc);
    ins_t e;
    e.word = w; e.imm = imm; e.two = two; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d instructions not delivered, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!ins_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic redirect(input logic [15:0] a);
    branch_valid = 1'b1; branch_addr = a; fetch_en = 1'b1;
    @(posedge clk); #1;
    branch_valid = 1'b0; fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [8];
    int   lat;
    logic [15:0] a1;

    vec[0] = '{16'h0003, 16'hADCC, 16'h8449, 1'b1, 16'h0005};
    vec[1] = '{16'h0005, 16'h1015, 16'h0000, 1'b0, 16'h0006};
    vec[2] = '{16'h0040, 16'h2000, 16'h1234, 1'b1, 16'h0042};
    vec[3] = '{16'h0050, 16'h3000, 16'hBEEF, 1'b0, 16'h0051};
    vec[4] = '{16'h0060, 16'h0000, 16'hFFFF, 1'b0, 16'h0061};
    vec[5] = '{16'hFFFF, 16'hE0AA, 16'h5A5A, 1'b1, 16'h0001};
    vec[6] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000};
    vec[7] = '{16'h0100, 16'hD123, 16'h0F0F, 1'b0, 16'h0101};

    rst = 1'b1; fetch_en = 1'b0; branch_valid = 1'b0; branch_addr = '0; ins_ready = 1'b0;
    rom[0] = 16'h1B5C;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", ROM_addr, 16'h0000);
    chk("rst_valid", ins_valid, 0);
    chk("rst_word", ins_word, 16'h0000);
    chk("rst_imm", ins_imm, 16'h0000);
    chk("rst_two", ins_two_word, 0);
    chk("rst_pc", ins_pc, 16'h0000);

    // First fetch straight out of reset.
    rst = 1'b0; fetch_en = 1'b1; ins_ready = 1'b1;
    push(16'h1B5C, 16'h0000, 1'b0, 16'h0000);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    wait_valid(lat);
    chk("reset_latency", lat, 3);
    wait_drain("reset_fetch");
    chk("reset_valid_drop", ins_valid, 0);
    chk("reset_next_addr", ROM_addr, 16'h0001);

    // Table: one instruction per vector, fetch_en dropped right after the start edge.
    for (int i = 0; i < 8; i++) begin
      a1 = vec[i].addr + 16'd1;
      rom[vec[i].addr] = vec[i].w0;
      rom[a1] = vec[i].w1;
      push(vec[i].w0, vec[i].two ? vec[i].w1 : 16'h0000, vec[i].two, vec[i].addr);
      ins_ready = 1'b1;
      redirect(vec[i].addr);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), lat, vec[i].two ? 5 : 3);
      wait_drain($sformatf("vec%0d_drain", i));
      chk($sformatf("vec%0d_next_addr", i), ROM_addr, vec[i].nxt);
    end

    // Back-to-back two-word then one-word.
    rom[3] = 16'hADCC; rom[4] = 16'h8449; rom[5] = 16'h1015;
    push(16'hADCC, 16'h8449, 1'b1, 16'h0003);
    push(16'h1015, 16'h0000, 1'b0, 16'h0005);
    branch_valid = 1'b1; branch_addr = 16'h0003; fetch_en = 1'b1;
    @(posedge clk); #1;
    branch_valid = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() > 1; n++) begin
      @(posedge clk); #1;
    end
    fetch_en = 1'b0;
    wait_drain("b2b");
    chk("b2b_next_addr", ROM_addr, 16'h0006);

    // Decoder stall in OUT.
    rom[16'h0020] = 16'h1111;
    ins_ready = 1'b0;
    redirect(16'h0020);
    wait_valid(lat);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("stall_valid", ins_valid, 1);
      chk("stall_word", ins_word, 16'h1111);
      chk("stall_rom_addr", ROM_addr, 16'h0020);
    end
    push(16'h1111, 16'h0000, 1'b0, 16'h0020);
    ins_ready = 1'b1;
    wait_drain("stall_accept");
    chk("stall_next_addr", ROM_addr, 16'h0021);

    // Branch while the second word is in flight (F2): aborted fetch never appears.
    rom[16'h0030] = 16'h2AAA; rom[16'h0031] = 16'h7777; rom[8] = 16'h1008;
    push(16'h1008, 16'h0000, 1'b0, 16'h0008);
    branch_valid = 1'b1; branch_addr = 16'h0030; fetch_en = 1'b1;
    @(posedge clk); #1;
    branch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    redirect(16'h0008);
    wait_drain("branch_f2");
    chk("branch_f2_pc", ins_pc, 16'h0008);
    chk("branch_f2_next_addr", ROM_addr, 16'h0009);

    // Branch coinciding with an accept: instruction kept, pc goes to the target.
    rom[16'h0038] = 16'h1038; rom[16'h0039] = 16'h0000;
    push(16'h1038, 16'h0000, 1'b0, 16'h0038);
    push(16'h1008, 16'h0000, 1'b0, 16'h0008);
    branch_valid = 1'b1; branch_addr = 16'h0038; fetch_en = 1'b1;
    @(posedge clk); #1;
    branch_valid = 1'b0;
    wait_valid(lat);
    chk("branch_acc_latency", lat, 3);
    redirect(16'h0008);
    wait_drain("branch_accept");
    chk("branch_acc_pc", ins_pc, 16'h0008);

    // Reset during C2 aborts the two-word fetch; restart from address 0.
    rom[16'h0070] = 16'h2070; rom[16'h0071] = 16'h9999; rom[0] = 16'h1B5C;
    branch_valid = 1'b1; branch_addr = 16'h0070; fetch_en = 1'b1;
    @(posedge clk); #1;
    branch_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("c2_rst_valid", ins_valid, 0);
    chk("c2_rst_rom_addr", ROM_addr, 16'h0000);
    chk("c2_rst_two", ins_two_word, 0);
    @(posedge clk); #1;
    push(16'h1B5C, 16'h0000, 1'b0, 16'h0000);
    rst = 1'b0;
    chk("c2_restart_addr", ROM_addr, 16'h0000);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    wait_drain("c2_restart");
    chk("c2_restart_next", ROM_addr, 16'h0001);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
